// File: rtl/console_pkg.sv
// Shared types and constants for the MMIO console transmitter.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  localparam logic [31:0] FINI_CODE_DEFAULT = 32'h0002_0000;

endpackage

// File: rtl/sync_fifo.sv
// Generic circular FIFO: registered count/full/empty, dout shows the head entry, synchronous active-low reset.
// Push on full and pop on empty are the caller's responsibility to avoid; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop_i)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/mmio_console_tx.sv
// MMIO console: stores to addr[31]=1 become 8N1 frames on txd_o (txd low two edges after accept); stall_o holds the CPU while the buffer is full.
// Build macro CONSOLE_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register buffers one byte.
module mmio_console_tx
  import console_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] FINI_CODE    = FINI_CODE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_wvalid_i,
  input  logic [31:0] dbus_wdata_i,
  output logic        stall_o,
  output logic        txd_o,
  output logic        tx_idle_o,
  output logic        fini_o
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam int             DATA_BITS = FRAME_BITS - 2;

  logic       w_hit;
  logic       w_is_fini;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_pop_dat;
  logic       w_baud_done;
  logic       w_unused;

  logic       r_fini_pend;
  logic       r_fini;
  logic       r_tx_idle;
  logic       r_txd;
  tx_state_t  r_state;
  logic [BW-1:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_shift;

  assign w_hit     = rst_n & dbus_wvalid_i & dbus_addr_i[31];
  assign w_is_fini = (dbus_wdata_i == FINI_CODE);
  // Finish requests and post-finish writes never stall; they bypass the buffer.
  assign stall_o   = w_hit & w_full & ~w_is_fini & ~r_fini_pend;
  assign w_accept  = w_hit & ~stall_o;
  assign w_push    = w_accept & ~w_is_fini & ~r_fini_pend;

`ifdef CONSOLE_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] w_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (dbus_wdata_i[7:0]),
    .dout_o  (w_pop_dat),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign w_unused = ^{dbus_addr_i[30:0], w_count};
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic       r_hold_vld;
  logic [7:0] r_hold_dat;

  // Push never coincides with pop: an occupied register stalls all byte writes.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_hold_vld <= 1'b0;
      r_hold_dat <= '0;
    end else if (w_push) begin
      r_hold_vld <= 1'b1;
      r_hold_dat <= dbus_wdata_i[7:0];
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end

  assign w_full    = r_hold_vld;
  assign w_empty   = ~r_hold_vld;
  assign w_pop_dat = r_hold_dat;
  assign w_unused  = ^dbus_addr_i[30:0];
`endif

  assign w_baud_done = (r_baud == '0);
  assign w_pop = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_done));

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= BAUD_MAX;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= w_pop_dat;
            r_baud  <= BAUD_MAX;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_baud  <= BAUD_MAX;
            r_bit   <= '0;
            r_state <= DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud  <= BAUD_MAX;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'(DATA_BITS - 1)) begin
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        STOP: begin
          if (w_baud_done) begin
            r_baud <= BAUD_MAX;
            if (w_pop) begin
              r_shift <= w_pop_dat;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // txd follows the state one edge late, so the frame starts two edges after accept.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_txd <= 1'b1;
    end else begin
      case (r_state)
        START:   r_txd <= 1'b0;
        DATA:    r_txd <= r_shift[0];
        default: r_txd <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_tx_idle   <= 1'b1;
      r_fini      <= 1'b0;
      r_fini_pend <= 1'b0;
    end else begin
      r_tx_idle <= w_empty & (r_state == IDLE);
      if (w_accept & w_is_fini) begin
        r_fini_pend <= 1'b1;
      end
      // Sampling IDLE one edge late lines fini up with the end of the last stop bit on the wire.
      if (r_fini_pend & w_empty & (r_state == IDLE)) begin
        r_fini <= 1'b1;
      end
    end
  end

  assign txd_o     = r_txd;
  assign tx_idle_o = r_tx_idle;
  assign fini_o    = r_fini;

endmodule

// File: tb/tb_mmio_console_tx.sv
// Bench for mmio_console_tx: wire-timeline reference model checked every cycle, plus literal frame/stall/finish expectations.
module tb_mmio_console_tx;

  localparam int CPB = 4;
  localparam int FD  = 4;
`ifdef CONSOLE_FIFO_EN
  localparam int DEPTH = FD;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] FINI  = 32'h0002_0000;
  localparam logic [31:0] CONS  = 32'h8000_0000;
  localparam int          HMAX  = 16000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dbus_addr_i = '0;
  logic        dbus_wvalid_i = 1'b0;
  logic [31:0] dbus_wdata_i = '0;
  logic        stall_o, txd_o, tx_idle_o, fini_o;

  always #5 clk = ~clk;

  mmio_console_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD),
    .FINI_CODE    (FINI)
  ) dut (
    .clk_i         (clk),
    .rst_n         (rst_n),
    .dbus_addr_i   (dbus_addr_i),
    .dbus_wvalid_i (dbus_wvalid_i),
    .dbus_wdata_i  (dbus_wdata_i),
    .stall_o       (stall_o),
    .txd_o         (txd_o),
    .tx_idle_o     (tx_idle_o),
    .fini_o        (fini_o)
  );

  int tests = 0;
  int fails = 0;
  int t = 0;

  // Reference model: byte queue plus the wire timeline of the last frame started.
  logic [7:0] q[$];
  bit         m_fini_pend = 1'b0;
  bit         m_fini = 1'b0;
  bit         m_idle = 1'b1;
  bit         m_tx_idle = 1'b1;
  int         free_at = 0;
  int         last_pop = -1000;
  logic [7:0] last_byte = '0;

  logic hist_txd  [HMAX];
  logic hist_idle [HMAX];

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, t, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  function automatic logic exp_txd();
    int d;
    int k;
    d = t - last_pop;
    if (d < 1 || d > 10 * CPB) return 1'b1;
    k = (d - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return last_byte[k - 1];
  endfunction

  task automatic step(input logic rst, input logic vld, input logic [31:0] addr,
                      input logic [31:0] data, output logic stalled);
    logic m_stall;
    bit   popped;
    @(negedge clk);
    rst_n = rst;
    dbus_wvalid_i = vld;
    dbus_addr_i = addr;
    dbus_wdata_i = data;
    #1;
    m_stall = rst && vld && addr[31] && (q.size() == DEPTH) && (data != FINI) && !m_fini_pend;
    check("stall", stall_o, m_stall);
    stalled = m_stall;
    @(posedge clk);
    t++;
    if (!rst) begin
      q.delete();
      m_fini_pend = 1'b0;
      m_fini = 1'b0;
      m_tx_idle = 1'b1;
      m_idle = 1'b1;
      free_at = t;
      last_pop = -1000;
    end else begin
      m_tx_idle = (q.size() == 0) && m_idle;
      if (m_fini_pend && q.size() == 0 && m_idle) m_fini = 1'b1;
      popped = 1'b0;
      if (q.size() > 0 && t >= free_at) begin
        last_byte = q.pop_front();
        last_pop = t;
        free_at = t + 10 * CPB;
        popped = 1'b1;
      end
      m_idle = !popped && (t >= free_at);
      if (vld && addr[31] && !m_stall) begin
        if (data == FINI) m_fini_pend = 1'b1;
        else if (!m_fini_pend) q.push_back(data[7:0]);
      end
    end
    #1;
    check("txd", txd_o, exp_txd());
    check("tx_idle", tx_idle_o, m_tx_idle);
    check("fini", fini_o, m_fini);
    if (t < HMAX) begin
      hist_txd[t] = txd_o;
      hist_idle[t] = tx_idle_o;
    end
  endtask

  task automatic idle(input int n);
    logic s;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, s);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, output int nstall);
    logic s;
    nstall = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b1, addr, data, s);
      if (!s) break;
      nstall++;
    end
    if (nstall >= 200) begin
      tests++;
      fails++;
      $display("FAIL store_timeout at cycle %0d: still stalled after %0d cycles, expected acceptance", t, nstall);
    end
  endtask

  function automatic int zeros(input int from, input int to);
    int z = 0;
    for (int i = from; i <= to; i++) if (hist_txd[i] !== 1'b1) z++;
    return z;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s;
    int         ns;
    int         n0;
    int         first_stall;
    int         r;
    logic [0:9] pat;
    logic       r_vld;
    logic [31:0] r_addr, r_data;
    int         rate;

    // Reset, including a console hit that must not stall during reset.
    step(1'b0, 1'b1, CONS, 32'h41, s);
    step(1'b0, 1'b0, '0, '0, s);
    check("rst_txd", txd_o, 1'b1);
    check("rst_idle", tx_idle_o, 1'b1);
    check("rst_fini", fini_o, 1'b0);
    idle(3);

    // Single byte 0x41: frame timing pinned bit by bit.
    store(CONS, 32'h41, ns);
    n0 = t;
    idle(45);
    pat = 10'b0100000101;
    check("lat_n1_high", hist_txd[n0 + 1], 1'b1);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < CPB; j++)
        check("frame41", hist_txd[n0 + 2 + CPB * k + j], pat[k]);
    check("idle41_n0", hist_idle[n0], 1'b1);
    check("idle41_n1", hist_idle[n0 + 1], 1'b0);
    check("idle41_n41", hist_idle[n0 + 41], 1'b0);
    check("idle41_n42", hist_idle[n0 + 42], 1'b1);

    // Six stores issued while a frame is in flight.
    store(CONS, 32'h55, ns);
    idle(2);
    first_stall = 0;
    for (int i = 0; i < 6; i++) begin
      store(CONS, 32'h60 + i, ns);
      if (ns > 0 && first_stall == 0) first_stall = i + 1;
    end
`ifdef CONSOLE_FIFO_EN
    checki("first_stall", first_stall, 5);
`else
    checki("first_stall", first_stall, 2);
`endif
    idle(300);
    check("drain_idle", tx_idle_o, 1'b1);

    // Finish request behind queued bytes, then a store that must be discarded.
    store(CONS, 32'h31, ns);
    store(CONS, 32'h32, ns);
    store(CONS, 32'h33, ns);
    store(CONS, FINI, ns);
    checki("fini_nostall", ns, 0);
    store(CONS, 32'h42, ns);
    checki("post_fini_nostall", ns, 0);
    r = -1;
    for (int i = 0; i < 400 && r < 0; i++) begin
      idle(1);
      if (fini_o === 1'b1) r = t;
    end
    if (r < 0) begin
      tests++;
      fails++;
      $display("FAIL fini_timeout at cycle %0d: fini_o=%b, expected 1", t, fini_o);
    end else begin
      check("fini_bit7", hist_txd[r - 5], 1'b0);
      check("fini_stop_first", hist_txd[r - 4], 1'b1);
      check("fini_stop_last", hist_txd[r - 1], 1'b1);
      idle(60);
      checki("fini_discard_zeros", zeros(r, t), 0);
      check("fini_sticky", fini_o, 1'b1);
    end

    // Non-console address after reset.
    step(1'b0, 1'b0, '0, '0, s);
    idle(2);
    store(32'h0000_1000, 32'h41, ns);
    checki("noaddr_stall", ns, 0);
    n0 = t;
    idle(20);
    checki("noaddr_zeros", zeros(n0, t), 0);
    check("noaddr_idle", tx_idle_o, 1'b1);

    // Reset mid-DATA with bytes queued.
    store(CONS, 32'hA5, ns);
    store(CONS, 32'h3C, ns);
    store(CONS, 32'h0F, ns);
    idle(10);
    step(1'b0, 1'b0, '0, '0, s);
    check("midrst_txd", txd_o, 1'b1);
    check("midrst_idle", tx_idle_o, 1'b1);
    n0 = t;
    idle(80);
    checki("midrst_zeros", zeros(n0, t), 0);

    // Randomized traffic with rare finish codes and resets.
    r_vld = 1'b0;
    r_addr = '0;
    r_data = '0;
    s = 1'b0;
    rate = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) rate = $urandom_range(1, 8);
      if (!s) begin
        r_vld = ($urandom_range(0, rate) == 0);
        r_addr = {($urandom_range(0, 7) != 0), 31'($urandom)};
        r_data = ($urandom_range(0, 399) == 0) ? FINI : $urandom;
        if ($urandom_range(0, 699) == 0) begin
          step(1'b0, r_vld, r_addr, r_data, s);
          continue;
        end
      end
      step(1'b1, r_vld, r_addr, r_data, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
